// File: rtl/if_stage.sv
// ============================================================================
// if_stage -- RV32I instruction-fetch stage.
//
// Owns the PC and issues one fetch at a time over a req/ready + rvalid
// handshake. The fetched word lands in the IF/ID register, which drives the
// decode/control unit directly. A one-entry hold buffer absorbs a response
// that arrives while decode is stalled. Redirects flush IF/ID and discard any
// wrong-path response still in flight.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   imem_req/addr       fetch request (combinational from state/pc)
//   imem_ready          memory accepts the request this cycle
//   imem_rvalid/rdata   fetch response
//   stall               decode cannot accept; IF/ID holds
//   redirect/_pc        taken branch/jump target
//   if_id_valid/pc/instruction  registered IF/ID slot (NOP_INSN when invalid)
//   fetch_fault         misaligned redirect trapped
//
// Build option: IF_MISALIGN_TRAP_EN -- a redirect to a non-word-aligned
// target raises fetch_fault and parks the stage in FAULT until reset. Without
// it the target's low two bits are dropped and fetch_fault is tied low.
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DROP
`ifdef IF_MISALIGN_TRAP_EN
        , S_FAULT
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_pc, req_pc_nxt;
    logic [31:0] buf_pc, buf_pc_nxt;
    logic [31:0] buf_insn, buf_insn_nxt;
    logic        v, v_nxt;
    logic [31:0] ipc, ipc_nxt;
    logic [31:0] insn, insn_nxt;

    logic        redirect_en;
    logic [31:0] tgt;

`ifdef IF_MISALIGN_TRAP_EN
    logic fault, fault_nxt;
    logic misalign;
    // Once faulted the stage is frozen; further redirects are ignored.
    assign redirect_en = redirect && (state != S_FAULT);
    assign misalign    = (redirect_pc[1:0] != 2'b00);
    assign tgt         = redirect_pc;
    assign fetch_fault = fault;
`else
    logic unused_low_bits;
    assign redirect_en     = redirect;
    assign tgt             = {redirect_pc[31:2], 2'b00};
    assign unused_low_bits = ^redirect_pc[1:0];
    assign fetch_fault     = 1'b0;
`endif

    // Request is gated by rst_n so nothing is presented while reset is held.
    assign imem_req          = rst_n && (state == S_FETCH);
    assign imem_addr         = pc;
    assign if_id_valid       = v;
    assign if_id_pc          = ipc;
    assign if_id_instruction = insn;

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_pc_nxt   = req_pc;
        buf_pc_nxt   = buf_pc;
        buf_insn_nxt = buf_insn;
        v_nxt        = v;
        ipc_nxt      = ipc;
        insn_nxt     = insn;
`ifdef IF_MISALIGN_TRAP_EN
        fault_nxt    = fault;
`endif
        // Decode consumed the slot: bubble unless something new lands below.
        if (!stall) begin
            v_nxt    = 1'b0;
            insn_nxt = NOP_INSN;
        end

        unique case (state)
            S_FETCH: begin
                if (imem_ready) begin
                    req_pc_nxt = pc;
                    pc_nxt     = pc + 32'd4;
                    state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (!stall || !v) begin
                        v_nxt     = 1'b1;
                        ipc_nxt   = req_pc;
                        insn_nxt  = imem_rdata;
                        state_nxt = S_FETCH;
                    end else begin
                        buf_pc_nxt   = req_pc;
                        buf_insn_nxt = imem_rdata;
                        state_nxt    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    v_nxt     = 1'b1;
                    ipc_nxt   = buf_pc;
                    insn_nxt  = buf_insn;
                    state_nxt = S_FETCH;
                end
            end
            S_DROP: begin
                if (imem_rvalid) state_nxt = S_FETCH;
            end
`ifdef IF_MISALIGN_TRAP_EN
            S_FAULT: ;
`endif
            default: state_nxt = S_FETCH;
        endcase

        // Redirect overrides everything above. A request still in flight
        // after this edge (just accepted, or unanswered) must be drained.
        if (redirect_en) begin
            v_nxt    = 1'b0;
            ipc_nxt  = ipc;
            insn_nxt = NOP_INSN;
            pc_nxt   = tgt;
            if ((state == S_FETCH && imem_ready) ||
                ((state == S_WAIT || state == S_DROP) && !imem_rvalid))
                state_nxt = S_DROP;
            else
                state_nxt = S_FETCH;
`ifdef IF_MISALIGN_TRAP_EN
            // FAULT issues no requests and ignores rvalid, so an in-flight
            // response is simply swallowed.
            if (misalign) begin
                state_nxt = S_FAULT;
                fault_nxt = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            req_pc   <= 32'h0;
            buf_pc   <= 32'h0;
            buf_insn <= NOP_INSN;
            v        <= 1'b0;
            ipc      <= 32'h0;
            insn     <= NOP_INSN;
`ifdef IF_MISALIGN_TRAP_EN
            fault    <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            req_pc   <= req_pc_nxt;
            buf_pc   <= buf_pc_nxt;
            buf_insn <= buf_insn_nxt;
            v        <= v_nxt;
            ipc      <= ipc_nxt;
            insn     <= insn_nxt;
`ifdef IF_MISALIGN_TRAP_EN
            fault    <= fault_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed test-plan sequence with literal expectations,
// then randomized traffic. A transaction-level model (queue of outstanding
// fetches tagged wrong-path, queue of held responses) predicts the outputs,
// and a single negedge process compares the DUT against it every cycle.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ready, imem_rvalid, stall, redirect;
    logic [31:0] imem_addr, imem_rdata, redirect_pc;
    logic        if_id_valid, fetch_fault;
    logic [31:0] if_id_pc, if_id_instruction;

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_instruction(if_id_instruction), .fetch_fault(fetch_fault)
    );

    int errs = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] oq_pc[$];
    bit          oq_stale[$];
    logic [31:0] hq_pc[$];
    logic [31:0] hq_insn[$];
    logic [31:0] m_pc, m_ipc, m_insn;
    bit          m_v, m_fault;

    // A fetch may be issued only when nothing is in flight or held.
    function automatic bit m_req();
        return !m_fault && oq_pc.size() == 0 && hq_pc.size() == 0;
    endfunction

    task automatic model_reset();
        oq_pc.delete(); oq_stale.delete(); hq_pc.delete(); hq_insn.delete();
        m_pc = 32'h0; m_ipc = 32'h0; m_insn = NOP; m_v = 0; m_fault = 0;
    endtask

    task automatic model_update(input bit rdy, input bit rv, input logic [31:0] rd,
                                input bit stl, input bit rdr, input logic [31:0] rpc);
        bit acc, resp, r_stale;
        logic [31:0] r_pc;
        acc = m_req() && rdy;
        resp = rv && oq_pc.size() > 0;
        r_stale = 1; r_pc = 0;
        if (resp) begin
            r_pc = oq_pc.pop_front();
            r_stale = oq_stale.pop_front();
        end
        if (m_fault) return;
        if (rdr) begin
            if (acc) begin oq_pc.push_back(m_pc); oq_stale.push_back(1); end
            foreach (oq_stale[i]) oq_stale[i] = 1;
            hq_pc.delete(); hq_insn.delete();
            m_v = 0; m_insn = NOP;
`ifdef IF_MISALIGN_TRAP_EN
            if (rpc[1:0] != 2'b00) begin m_fault = 1; return; end
`endif
            m_pc = {rpc[31:2], 2'b00};
            return;
        end
        if (acc) begin
            oq_pc.push_back(m_pc); oq_stale.push_back(0);
            m_pc = m_pc + 32'd4;
        end
        if (resp && !r_stale) begin
            if (!stl || !m_v) begin m_v = 1; m_ipc = r_pc; m_insn = rd; end
            else begin hq_pc.push_back(r_pc); hq_insn.push_back(rd); end
        end else if (hq_pc.size() > 0 && !stl) begin
            m_v = 1; m_ipc = hq_pc.pop_front(); m_insn = hq_insn.pop_front();
        end else if (!stl) begin
            m_v = 0; m_insn = NOP;
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_req", {31'b0, imem_req}, {31'b0, m_req()});
            if (m_req()) chk("imem_addr", imem_addr, m_pc);
            chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_v});
            if (m_v) chk("if_id_pc", if_id_pc, m_ipc);
            chk("if_id_instruction", if_id_instruction, m_insn);
            chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
        end
    end

    // ---------------- memory responder ----------------
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h00A0_0113;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    // Entry/exit point: 1 time unit after a falling edge. Drives one cycle of
    // inputs, advances the model over the coming rising edge.
    task automatic step(input bit rdy, input bit stl, input bit rdr,
                        input logic [31:0] rpc, input bit spur, input int lat);
        bit rv, rdy_eff;
        logic [31:0] rd;
        rv = 0; rd = $urandom;
        if (mem_busy) begin
            if (mem_cnt == 0) begin rv = 1; rd = mem_data(mem_addr); mem_busy = 0; end
            else mem_cnt--;
        end else if (spur) rv = 1;
        rdy_eff = rdy && !mem_busy;
        imem_ready = rdy_eff; imem_rvalid = rv; imem_rdata = rd;
        stall = stl; redirect = rdr; redirect_pc = rpc;
        if (imem_req && rdy_eff) begin
            mem_busy = 1; mem_cnt = lat; mem_addr = imem_addr;
        end
        model_update(rdy_eff, rv, rd, stl, rdr, rpc);
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        chk_en = 0;
        rst_n = 0;
        imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
        stall = 0; redirect = 0; redirect_pc = 0;
        model_reset();
        #1;
        chk("rst imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst if_id_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rst if_id_pc", if_id_pc, 32'h0);
        chk("rst if_id_instruction", if_id_instruction, NOP);
        chk("rst fetch_fault", {31'b0, fetch_fault}, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1;
        chk_en = 1;
        #1;
        chk("release imem_req", {31'b0, imem_req}, 32'h1);
    endtask

    initial begin
        imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
        stall = 0; redirect = 0; redirect_pc = 0;
        model_reset();
        @(negedge clk); #1;
        do_reset();

        // Two fetches with a 1-cycle memory.
        chk("first addr", imem_addr, 32'h0);
        step(1, 0, 0, 0, 0, 0);
        chk("wait no req", {31'b0, imem_req}, 32'h0);
        step(0, 0, 0, 0, 0, 0);
        chk("ifid0 valid", {31'b0, if_id_valid}, 32'h1);
        chk("ifid0 pc", if_id_pc, 32'h0);
        chk("ifid0 insn", if_id_instruction, 32'h0050_0093);
        chk("second addr", imem_addr, 32'h4);
        step(1, 0, 0, 0, 0, 0);
        chk("bubble valid", {31'b0, if_id_valid}, 32'h0);
        chk("bubble insn", if_id_instruction, NOP);
        step(0, 0, 0, 0, 0, 0);
        chk("ifid4 pc", if_id_pc, 32'h4);
        chk("ifid4 insn", if_id_instruction, 32'h00A0_0113);

        // Response for 0x8 while stalled -> hold, then release.
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("hold no req", {31'b0, imem_req}, 32'h0);
        chk("hold keeps pc4", if_id_pc, 32'h4);
        step(0, 1, 0, 0, 0, 0);
        chk("hold still no req", {31'b0, imem_req}, 32'h0);
        step(0, 0, 0, 0, 0, 0);
        chk("released pc8", if_id_pc, 32'h8);
        chk("released valid", {31'b0, if_id_valid}, 32'h1);
        chk("then addr C", imem_addr, 32'hC);

        // Redirect while waiting for 0x10 -> drop the late response.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("addr 10", imem_addr, 32'h10);
        step(1, 0, 0, 0, 0, 2);
        step(0, 0, 1, 32'h100, 0, 0);
        chk("drop no req", {31'b0, imem_req}, 32'h0);
        chk("drop invalid", {31'b0, if_id_valid}, 32'h0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("after drop addr", imem_addr, 32'h100);
        chk("after drop invalid", {31'b0, if_id_valid}, 32'h0);

        // Redirect and response in the same WAIT cycle.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h100, 0, 0);
        chk("same-cycle invalid", {31'b0, if_id_valid}, 32'h0);
        chk("same-cycle addr", imem_addr, 32'h100);

        // PC wrap.
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        chk("wrap addr", imem_addr, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("wrap ifid pc", if_id_pc, 32'hFFFF_FFFC);
        chk("wrapped addr", imem_addr, 32'h0);

        // Misaligned redirect.
        step(0, 0, 1, 32'h102, 0, 0);
`ifdef IF_MISALIGN_TRAP_EN
        chk("fault set", {31'b0, fetch_fault}, 32'h1);
        chk("fault no req", {31'b0, imem_req}, 32'h0);
`else
        chk("aligned addr", imem_addr, 32'h100);
        chk("no fault", {31'b0, fetch_fault}, 32'h0);
`endif

        // Reset with a fetch in flight; its response arrives after release.
        step(1, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 0);
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("stale after reset", {31'b0, if_id_valid}, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] rpc;
            rpc = $urandom;
            if ($urandom_range(15) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            if ($urandom_range(7) != 0) rpc[1:0] = 2'b00;
            step($urandom_range(3) != 0, $urandom_range(2) == 0,
                 $urandom_range(11) == 0, rpc,
                 $urandom_range(9) == 0, int'($urandom_range(2)));
            if (i % 700 == 699) do_reset();
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
